// File: rtl/calc_operand_mux_pkg.sv
// rtl/calc_operand_mux_pkg.sv - shared mode constants and state type for the operand mux
package calc_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/calc_operand_mux_if.sv
// rtl/calc_operand_mux_if.sv - producer-side and consumer-side handshake bundle of the operand mux
interface calc_operand_mux_if #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/calc_operand_mux_rr_arbiter.sv
// rtl/calc_operand_mux_rr_arbiter.sv - combinational round-robin search starting at ptr, wrapping modulo NUM_CH
module calc_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_found
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      // Explicit wrap keeps idx below NUM_CH even when NUM_CH is not a power of two.
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!grant_found && (idx == j) && valid[j]) begin
          grant_found = 1'b1;
          grant       = SEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/calc_operand_mux.sv
// rtl/calc_operand_mux.sv - registered, handshaked N-channel operand mux (fixed select or round-robin)
// Optional sticky out-of-range select flag enabled by CALC_MUX_SELERR_EN.
module calc_operand_mux
  import calc_mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
`ifdef CALC_MUX_SELERR_EN
  output logic             sel_err,
`endif
  calc_operand_mux_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic             can_accept;
  logic             accept;
  int               sel_int;

  assign sel_int = int'(sel);

  calc_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .valid       (bus.in_valid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_found (rr_found)
  );

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (mode == MODE_RR) begin
      grant = rr_grant;
      found = rr_found;
    end else begin
      // Out-of-range sel matches no channel, so it grants nothing.
      for (int i = 0; i < NUM_CH; i++) begin
        if ((sel_int == i) && bus.in_valid[i]) begin
          found = 1'b1;
          grant = SEL_W'(i);
        end
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || bus.out_ready;
  assign accept     = found && can_accept && !rst;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_ready[i] = accept && (grant == SEL_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = FULL;
      ch_d    = grant;
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant == SEL_W'(i)) data_d = bus.in_data[i*WIDTH +: WIDTH];
      end
      if (mode == MODE_RR) begin
        ptr_d = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;

`ifdef CALC_MUX_SELERR_EN
  logic sel_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if ((mode == MODE_FIXED) && (sel_int >= NUM_CH) && (|bus.in_valid)) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_calc_operand_mux.sv
// tb/tb_calc_operand_mux.sv - directed-vector bench for calc_operand_mux (4-channel and 3-channel builds)
module tb_calc_operand_mux;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       mode, mode2;
  logic [1:0] sel, sel2;
`ifdef CALC_MUX_SELERR_EN
  logic       sel_err, sel_err2;
`endif

  int vectors     = 0;
  int miscompares = 0;

  calc_operand_mux_if #(.WIDTH(8), .NUM_CH(4)) bus ();
  calc_operand_mux_if #(.WIDTH(8), .NUM_CH(3)) bus2 ();

  calc_operand_mux #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .sel     (sel),
`ifdef CALC_MUX_SELERR_EN
    .sel_err (sel_err),
`endif
    .bus     (bus.slave)
  );

  calc_operand_mux #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk     (clk),
    .rst     (rst2),
    .mode    (mode2),
    .sel     (sel2),
`ifdef CALC_MUX_SELERR_EN
    .sel_err (sel_err2),
`endif
    .bus     (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 4; i++) bus.in_data[i*8 +: 8] = base + 8'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 1'b1;
    sel = 2'd0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    set_data(8'h10);
    tick();
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b ch=%0d d=%h expected v=0 ch=0 d=00",
               bus.out_valid, bus.out_ch, bus.out_data);
    end
    vectors++;
    if (bus.in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b expected 0001", bus.in_ready);
    end
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 2'd0, 8'h10}) begin
      miscompares++;
      $display("FAIL reset_first_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=10",
               bus.out_valid, bus.out_ch, bus.out_data);
    end
    bus.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0;
    sel = 2'd2;
    set_data(8'h00);
    bus.in_data[2*8 +: 8] = 8'h5A;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL fixed_in_ready: got %b expected 0100", bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready} !== {1'b1, 2'd2, 8'h5A, 4'b0100}) begin
        miscompares++;
        $display("FAIL fixed_stream[%0d]: got v=%b ch=%0d d=%h rdy=%b expected v=1 ch=2 d=5a rdy=0100",
                 k, bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready);
      end
    end
    bus.in_valid = 4'b0000;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_drain: got out_valid=%b expected 0", bus.out_valid);
    end
`ifdef CALC_MUX_SELERR_EN
    vectors++;
    if (sel_err !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_sel_err_inrange: got %b expected 0", sel_err);
    end
`endif
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch [5];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    mode = 1'b1;
    set_data(8'h10);
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_ch[k], 8'h10 + 8'(exp_ch[k])}) begin
        miscompares++;
        $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 k, bus.out_valid, bus.out_ch, bus.out_data, exp_ch[k], 8'h10 + 8'(exp_ch[k]));
      end
    end
    bus.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0;
    sel = 2'd1;
    set_data(8'h00);
    bus.in_data[1*8 +: 8] = 8'h33;
    bus.in_data[3*8 +: 8] = 8'h77;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    tick();
    sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if ({bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready} !== {1'b1, 2'd1, 8'h33, 4'b0000}) begin
        miscompares++;
        $display("FAIL stall[%0d]: got v=%b ch=%0d d=%h rdy=%b expected v=1 ch=1 d=33 rdy=0000",
                 k, bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b expected 1000", bus.in_ready);
    end
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 2'd3, 8'h77}) begin
      miscompares++;
      $display("FAIL stall_release_out: got v=%b ch=%0d d=%h expected v=1 ch=3 d=77",
               bus.out_valid, bus.out_ch, bus.out_data);
    end
    bus.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    mode = 1'b1;
    set_data(8'h40);
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0100;
    tick();
    bus.in_valid = 4'b0000;
    tick();
    bus.in_valid = 4'b0101;
    #1;
    vectors++;
    if (bus.in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_grant0: got %b expected 0001", bus.in_ready);
    end
    tick();
    vectors++;
    if ({bus.out_ch, bus.in_ready} !== {2'd0, 4'b0100}) begin
      miscompares++;
      $display("FAIL wrap_grant2: got ch=%0d rdy=%b expected ch=0 rdy=0100", bus.out_ch, bus.in_ready);
    end
    tick();
    vectors++;
    if ({bus.out_ch, bus.out_data} !== {2'd2, 8'h42}) begin
      miscompares++;
      $display("FAIL wrap_out2: got ch=%0d d=%h expected ch=2 d=42", bus.out_ch, bus.out_data);
    end
    bus.in_valid = 4'b1001;
    #1;
    vectors++;
    if (bus.in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_ptr3: got %b expected 1000", bus.in_ready);
    end
    bus.in_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    logic [1:0] exp_ch [4];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 3; i++) bus2.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    mode2 = 1'b0;
    sel2 = 2'd3;
    bus2.in_valid = 3'b111;
    bus2.out_ready = 1'b1;
    rst2 = 1'b0;
    #1;
    vectors++;
    if (bus2.in_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL oor_in_ready: got %b expected 000", bus2.in_ready);
    end
    tick();
    vectors++;
    if (bus2.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_no_accept: got out_valid=%b expected 0", bus2.out_valid);
    end
`ifdef CALC_MUX_SELERR_EN
    vectors++;
    if (sel_err2 !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_sel_err_set: got %b expected 1", sel_err2);
    end
`endif
    sel2 = 2'd0;
    #1;
    vectors++;
    if (bus2.in_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL oor_sel0_ready: got %b expected 001", bus2.in_ready);
    end
    tick();
    vectors++;
    if ({bus2.out_valid, bus2.out_ch, bus2.out_data} !== {1'b1, 2'd0, 8'hA0}) begin
      miscompares++;
      $display("FAIL oor_sel0_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=a0",
               bus2.out_valid, bus2.out_ch, bus2.out_data);
    end
`ifdef CALC_MUX_SELERR_EN
    vectors++;
    if (sel_err2 !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_sel_err_sticky: got %b expected 1", sel_err2);
    end
`endif
    mode2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({bus2.out_valid, bus2.out_ch, bus2.out_data} !== {1'b1, exp_ch[k], 8'hA0 + 8'(exp_ch[k])}) begin
        miscompares++;
        $display("FAIL rr3_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d",
                 k, bus2.out_valid, bus2.out_ch, bus2.out_data, exp_ch[k]);
      end
    end
    rst2 = 1'b1;
    tick();
    vectors++;
    if ({bus2.out_valid, bus2.out_ch, bus2.out_data} !== 11'h000) begin
      miscompares++;
      $display("FAIL rr3_reset_drop: got v=%b ch=%0d d=%h expected v=0 ch=0 d=00",
               bus2.out_valid, bus2.out_ch, bus2.out_data);
    end
`ifdef CALC_MUX_SELERR_EN
    vectors++;
    if (sel_err2 !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_sel_err_clear: got %b expected 0", sel_err2);
    end
`endif
  endtask

  initial begin
    rst2 = 1'b1;
    mode2 = 1'b0;
    sel2 = 2'd0;
    bus2.in_valid = 3'b000;
    bus2.in_data = '0;
    bus2.out_ready = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_operand_mux.md
Name: calc_operand_mux

Overview:
Parametrised N-channel, WIDTH-bit operand multiplexer for the calculator datapath. It is the registered, handshaked successor to the plain 2-to-1 select.
- Takes operands from several producers (keypad latch, accumulator, memory register, constant ROM) and delivers one operand per transfer to the ALU stage.
- Selection is either by an FSM-driven fixed select or by round-robin arbitration.
- Output is a one-entry registered stage with valid/ready flow control.

Parameters:
- WIDTH, 8, operand width in bits (≥1).
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, derived localparam = max(1, $clog2(NUM_CH)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = MODE_FIXED (use sel), 1 = MODE_RR (round-robin).
- sel  input  SEL_W  channel select, used only in MODE_FIXED.
- in_valid  input  NUM_CH  per-channel data valid.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel accept; at most one bit high.
- out_valid  output  1  output register holds an operand.
- out_data  output  WIDTH  registered operand.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- **Clock and reset:** one clock (clk); reset rst is synchronous and active-high. On reset: out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0, state=EMPTY. Reset mid-transfer drops any held operand.
- **FSM states:**
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - can_accept = (state==EMPTY) || out_ready.
- **Grant:**
  - MODE_FIXED: grant = sel if sel<NUM_CH and in_valid[sel]; otherwise no grant.
  - MODE_RR: grant = first i with in_valid[i], searching ptr, ptr+1, … wrapping modulo NUM_CH.
- **Ready:** in_ready[g]=1 only for the granted channel g and only when can_accept; all other bits are 0. in_ready is combinational from in_valid/sel/mode/state.
- **Transfer:** when in_valid[g] && in_ready[g], the next cycle has out_data=in_data[g], out_ch=g, state=FULL. Latency is 1 cycle from accept to out_valid.
- **Drain:** when out_valid && out_ready with no new accept → state=EMPTY. A simultaneous drain and accept stays FULL with the new data, giving full throughput of 1 operand/cycle.
- **Stall:** while out_valid && !out_ready, out_data and out_ch hold stable and in_ready=0.
- **RR pointer:** ptr updates only on an accept in MODE_RR: ptr ← (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0. ptr is unchanged in MODE_FIXED.
- **Mode/sel changes:** mode and sel are sampled every cycle and affect only the next accept; they never alter a held operand.
- **Boundaries:**
  - No valid input → no accept; state follows drain.
  - Out-of-range sel in fixed mode → no accept.
  - NUM_CH not a power of 2 → RR wrap uses modulo, never an index ≥NUM_CH.

Optional Feature:
- Macro: CALC_MUX_SELERR_EN.
- Defined: adds output port sel_err (1 bit). sel_err is sticky and set the cycle after mode==MODE_FIXED && sel>=NUM_CH && |in_valid. It is cleared only by rst (reset value 0).
- Undefined: the port and its logic are absent; out-of-range sel silently grants nothing.

Decomposition:
- Package calc_mux_pkg holds:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - state enum {EMPTY, FULL}.
- Sub-module calc_rr_arbiter is combinational, parametrised on NUM_CH.
  - Inputs: valid vector, ptr.
  - Outputs: grant index, grant_found.
  - calc_operand_mux instantiates it for MODE_RR.

Test Plan (NUM_CH=4, WIDTH=8):
1. Reset: assert rst 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000 during reset; first RR grant after release is ch0.
2. Fixed select: mode=0, sel=2, in_valid=1111, in_data ch2=0x5A, out_ready=1 → in_ready=0100; next cycle out_valid=1, out_data=0x5A, out_ch=2; sustained 1 operand/cycle.
3. Round-robin fairness: mode=1, in_valid=1111, data chi=0x10+i, out_ready=1 → out_ch sequence 0,1,2,3,0 with data 0x10,0x11,0x12,0x13,0x10.
4. Backpressure: FULL with out_data=0x33, out_ready=0 for 3 cycles, sel changed 1→3 → out_data stays 0x33, out_ch stays 1, in_ready=0000; on out_ready=1, accept ch3 in the same cycle.
5. Sparse RR wrap: ptr=3, in_valid=0101 → grant ch0, then ch2, then ch0; ptr after the ch2 grant is 3.
6. Out-of-range / feature: NUM_CH=3 build, mode=0, sel=3, in_valid=111 → no accept, out_valid stays 0. With CALC_MUX_SELERR_EN, sel_err=1 next cycle and stays 1 after sel=0 until rst.
